ir_frame_tx: RTL and testbench



---
 rtl/ir_pkg.sv | 41 ++++
 rtl/ir_symbol_timer.sv | 51 +++++
 rtl/ir_frame_tx.sv | 194 +++++++++++++++++++
 tb/tb_ir_frame_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared state encoding, default 125 MHz timing constants and small helpers
// for the infrared frame transmitter.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEG0,
        S_GAP,
        S_SEG1,
        S_TAIL,
        S_RPT_GAP
    } ir_state_t;

    // 125 MHz clock: 38 kHz carrier, 9/4.5 ms header, 750 us marks,
    // 1.2/2.25 ms bits, 20 ms connect gap, 40 ms repeat gap.
    localparam int D_CARRIER_PERIOD = 3289;
    localparam int D_CARRIER_HIGH   = 1645;
    localparam int D_HDR_MARK       = 1125000;
    localparam int D_HDR_TOTAL      = 1687500;
    localparam int D_BIT_MARK       = 93750;
    localparam int D_ZERO_TOTAL     = 150000;
    localparam int D_ONE_TOTAL      = 281250;
    localparam int D_GAP_MARK       = 93750;
    localparam int D_GAP_TOTAL      = 2593750;
    localparam int D_TAIL_MARK      = 93750;
    localparam int D_RPT_GAP        = 5000000;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit to send at sequence position pos of an nbits-wide segment.
    function automatic logic pick_bit(input logic [63:0] data, input int nbits,
                                      input int pos, input logic msb);
        logic [5:0] idx;
        idx = 6'(msb ? (nbits - 1 - pos) : pos);
        return data[idx];
    endfunction

endpackage

// File: rtl/ir_symbol_timer.sv
// One pulse-distance symbol: mark for mark_len cycles, then space until
// total_len cycles have elapsed; sym_done flags the final cycle.
module ir_symbol_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] mark_len,
    input  logic [W-1:0] total_len,
    output logic         mark,
    output logic         sym_done
);

    logic [W-1:0] cnt;
    logic [W-1:0] tot;
    logic [W-1:0] mlen;
    logic         active;

    assign sym_done = active && (cnt == tot - W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            tot    <= '0;
            mlen   <= '0;
            active <= 1'b0;
            mark   <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            active <= 1'b0;
            mark   <= 1'b0;
        end else if (load) begin
            // Load wins over sym_done so symbols chain with no idle cycle.
            cnt    <= '0;
            tot    <= total_len;
            mlen   <= mark_len;
            active <= 1'b1;
            mark   <= (mark_len != '0);
        end else if (sym_done) begin
            cnt    <= '0;
            active <= 1'b0;
            mark   <= 1'b0;
        end else if (active) begin
            cnt    <= cnt + W'(1);
            mark   <= ((cnt + W'(1)) < mlen);
        end
    end

endmodule

// File: rtl/ir_frame_tx.sv
// Two-segment pulse-distance IR frame transmitter with optional repeats:
// FSM and bit sequencing here, symbol timing in ir_symbol_timer.
module ir_frame_tx import ir_pkg::*; #(
    parameter int SEG0_BITS      = 35,
    parameter int SEG1_BITS      = 32,
    parameter int CARRIER_PERIOD = D_CARRIER_PERIOD,
    parameter int CARRIER_HIGH   = D_CARRIER_HIGH,
    parameter int T_HDR_MARK     = D_HDR_MARK,
    parameter int T_HDR_TOTAL    = D_HDR_TOTAL,
    parameter int T_BIT_MARK     = D_BIT_MARK,
    parameter int T_ZERO_TOTAL   = D_ZERO_TOTAL,
    parameter int T_ONE_TOTAL    = D_ONE_TOTAL,
    parameter int T_GAP_MARK     = D_GAP_MARK,
    parameter int T_GAP_TOTAL    = D_GAP_TOTAL,
    parameter int T_TAIL_MARK    = D_TAIL_MARK,
    parameter int T_RPT_GAP      = D_RPT_GAP,
    parameter int ENV_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [SEG0_BITS-1:0] seg0_data,
    input  logic [SEG1_BITS-1:0] seg1_data,
    input  logic                 msb_first,
    input  logic [1:0]           repeat_cnt,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 ir_env,
    output logic                 ir_mod
);

    localparam int T_MAX = imax(imax(imax(T_HDR_TOTAL, T_ONE_TOTAL),
                                     imax(T_ZERO_TOTAL, T_GAP_TOTAL)),
                                imax(T_TAIL_MARK, T_RPT_GAP));
    localparam int TW = $clog2(T_MAX + 1);
    localparam int BW = $clog2(imax(SEG0_BITS, SEG1_BITS)) + 1;
    localparam int CW = $clog2(CARRIER_PERIOD + 1);

    ir_state_t            state, state_nx;
    logic [SEG0_BITS-1:0] seg0_q;
    logic [SEG1_BITS-1:0] seg1_q;
    logic                 msb_q;
    logic [1:0]           rpt_q, rpt_nx;
    logic [BW-1:0]        pos_q, pos_nx, pos_inc;
    logic [CW-1:0]        car_cnt;
    logic                 done_q, done_nx, cap;
    logic                 ld, mark, sym_done;
    logic [TW-1:0]        ld_mark, ld_total;
    logic                 b0_first, b0_next, b1_first, b1_next;

    assign pos_inc  = pos_q + BW'(1);
    assign b0_first = pick_bit(64'(seg0_q), SEG0_BITS, 0, msb_q);
    assign b0_next  = pick_bit(64'(seg0_q), SEG0_BITS, int'(pos_inc), msb_q);
    assign b1_first = pick_bit(64'(seg1_q), SEG1_BITS, 0, msb_q);
    assign b1_next  = pick_bit(64'(seg1_q), SEG1_BITS, int'(pos_inc), msb_q);

    function automatic logic [TW-1:0] bit_total(input logic b);
        return b ? TW'(T_ONE_TOTAL) : TW'(T_ZERO_TOTAL);
    endfunction

    always_comb begin
        state_nx = state;
        pos_nx   = pos_q;
        rpt_nx   = rpt_q;
        cap      = 1'b0;
        done_nx  = 1'b0;
        ld       = 1'b0;
        ld_mark  = '0;
        ld_total = '0;
        case (state)
            S_IDLE: if (tx_valid) begin
                cap      = 1'b1;
                rpt_nx   = repeat_cnt;
                ld       = 1'b1;
                ld_mark  = TW'(T_HDR_MARK);
                ld_total = TW'(T_HDR_TOTAL);
                state_nx = S_HDR;
            end
            S_HDR: if (sym_done) begin
                ld       = 1'b1;
                pos_nx   = '0;
                ld_mark  = TW'(T_BIT_MARK);
                ld_total = bit_total(b0_first);
                state_nx = S_SEG0;
            end
            S_SEG0: if (sym_done) begin
                ld = 1'b1;
                if (pos_q == BW'(SEG0_BITS - 1)) begin
                    ld_mark  = TW'(T_GAP_MARK);
                    ld_total = TW'(T_GAP_TOTAL);
                    state_nx = S_GAP;
                end else begin
                    pos_nx   = pos_inc;
                    ld_mark  = TW'(T_BIT_MARK);
                    ld_total = bit_total(b0_next);
                end
            end
            S_GAP: if (sym_done) begin
                ld       = 1'b1;
                pos_nx   = '0;
                ld_mark  = TW'(T_BIT_MARK);
                ld_total = bit_total(b1_first);
                state_nx = S_SEG1;
            end
            S_SEG1: if (sym_done) begin
                ld = 1'b1;
                if (pos_q == BW'(SEG1_BITS - 1)) begin
                    ld_mark  = TW'(T_TAIL_MARK);
                    ld_total = TW'(T_TAIL_MARK);
                    state_nx = S_TAIL;
                end else begin
                    pos_nx   = pos_inc;
                    ld_mark  = TW'(T_BIT_MARK);
                    ld_total = bit_total(b1_next);
                end
            end
            S_TAIL: if (sym_done) begin
                if (rpt_q != 2'd0) begin
                    // Repeat gap is a symbol with no mark.
                    rpt_nx   = rpt_q - 2'd1;
                    ld       = 1'b1;
                    ld_total = TW'(T_RPT_GAP);
                    state_nx = S_RPT_GAP;
                end else begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_RPT_GAP: if (sym_done) begin
                ld       = 1'b1;
                ld_mark  = TW'(T_HDR_MARK);
                ld_total = TW'(T_HDR_TOTAL);
                state_nx = S_HDR;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            rpt_nx   = rpt_q;
            cap      = 1'b0;
            ld       = 1'b0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            seg0_q  <= '0;
            seg1_q  <= '0;
            msb_q   <= 1'b0;
            rpt_q   <= '0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            car_cnt <= '0;
        end else begin
            state  <= state_nx;
            pos_q  <= pos_nx;
            rpt_q  <= rpt_nx;
            done_q <= done_nx;
            if (cap) begin
                seg0_q <= seg0_data;
                seg1_q <= seg1_data;
                msb_q  <= msb_first;
            end
            // Carrier phase restarts with each frame so the first mark
            // always begins on a carrier high.
            if (cap || car_cnt == CW'(CARRIER_PERIOD - 1))
                car_cnt <= '0;
            else
                car_cnt <= car_cnt + CW'(1);
        end
    end

    ir_symbol_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .load      (ld),
        .mark_len  (ld_mark),
        .total_len (ld_total),
        .mark      (mark),
        .sym_done  (sym_done)
    );

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign ir_env   = (ENV_ACTIVE_LOW != 0) ? ~mark : mark;
    assign ir_mod   = mark && (car_cnt < CW'(CARRIER_HIGH));

endmodule

// File: tb/tb_ir_frame_tx.sv
// Bench for ir_frame_tx with small timings: command table plus hand-written
// abort, reset and back-to-back sequences, checked by a mark/done scoreboard.
module tb_ir_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [2:0] seg0_data = '0;
    logic [1:0] seg1_data = '0;
    logic       msb_first = 1'b0;
    logic [1:0] repeat_cnt = '0;
    logic       abort = 1'b0;
    logic       busy, done, ir_env, ir_mod;

    ir_frame_tx #(
        .SEG0_BITS(3), .SEG1_BITS(2), .CARRIER_PERIOD(4), .CARRIER_HIGH(2),
        .T_HDR_MARK(8), .T_HDR_TOTAL(12), .T_BIT_MARK(2), .T_ZERO_TOTAL(4),
        .T_ONE_TOTAL(6), .T_GAP_MARK(2), .T_GAP_TOTAL(10), .T_TAIL_MARK(2),
        .T_RPT_GAP(5), .ENV_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .seg0_data(seg0_data), .seg1_data(seg1_data), .msb_first(msb_first),
        .repeat_cnt(repeat_cnt), .abort(abort), .busy(busy), .done(done),
        .ir_env(ir_env), .ir_mod(ir_mod)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int len; } mk_t;
    typedef struct {
        logic [2:0] s0;
        logic [1:0] s1;
        logic       msb;
        logic [1:0] rpt;
        int         busy;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   cur_exp_busy = 0;
    int   mstart = 0;
    logic prev_mark = 1'b0;
    logic mk_now;
    mk_t  mark_q[$];
    int   done_q[$];
    int   rise_log[$];
    mk_t  m;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail(input string n, input int a, input int e);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    endtask

    task automatic chk(input string n, input int a, input int e);
        if (a != e) fail(n, a, e);
        else total++;
    endtask

    // Expected mark windows of an accepted command, in absolute cycles.
    task automatic model_push(input int a);
        int t;
        int idx;
        t = a + 1;
        for (int f = 0; f <= int'(repeat_cnt); f++) begin
            mark_q.push_back('{t, 8}); t += 12;
            for (int k = 0; k < 3; k++) begin
                idx = msb_first ? 2 - k : k;
                mark_q.push_back('{t, 2});
                t += seg0_data[idx] ? 6 : 4;
            end
            mark_q.push_back('{t, 2}); t += 10;
            for (int k = 0; k < 2; k++) begin
                idx = msb_first ? 1 - k : k;
                mark_q.push_back('{t, 2});
                t += seg1_data[idx] ? 6 : 4;
            end
            mark_q.push_back('{t, 2}); t += 2;
            if (f < int'(repeat_cnt)) t += 5;
        end
    endtask

    always @(negedge clk) begin
        mk_now = ~ir_env;
        if (!rst || abort) begin
            mark_q.delete();
            done_q.delete();
            prev_mark = 1'b0;
        end else begin
            if (mk_now)
                chk("carrier", int'(ir_mod), int'(((cyc - acc_cyc - 1) % 4) < 2));
            else
                chk("mod_in_space", int'(ir_mod), 0);
            if (mk_now && !prev_mark) begin
                mstart = cyc;
                rise_log.push_back(cyc - acc_cyc);
            end
            if (!mk_now && prev_mark) begin
                if (mark_q.size() == 0) fail("mark_extra", mstart, -1);
                else begin
                    m = mark_q.pop_front();
                    chk("mark_start", mstart, m.st);
                    chk("mark_len", cyc - mstart, m.len);
                end
            end
            prev_mark = mk_now;
            if (done) begin
                if (done_q.size() == 0) fail("done_extra", cyc, -1);
                else chk("done_cycle", cyc, done_q.pop_front());
                chk("done_busy", int'(busy), 0);
                chk("done_ready", int'(tx_ready), 1);
            end
            if (tx_valid && tx_ready) begin
                acc_cyc = cyc;
                model_push(cyc);
                done_q.push_back(cyc + cur_exp_busy + 1);
            end
        end
    end

    task automatic set_cmd(input logic [2:0] s0, input logic [1:0] s1,
                           input logic msb, input logic [1:0] r, input int eb);
        seg0_data = s0; seg1_data = s1; msb_first = msb; repeat_cnt = r;
        cur_exp_busy = eb;
    endtask

    task automatic wait_accept(output int a);
        a = -1;
        for (int i = 0; i < 500 && a < 0; i++) begin
            @(negedge clk);
            if (tx_ready && rst && !abort) a = cyc;
        end
        if (a < 0) fail("accept_timeout", 0, 1);
    endtask

    task automatic send(output int a);
        tx_valid = 1'b1;
        wait_accept(a);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000 && done_q.size() != 0; i++) @(negedge clk);
        if (done_q.size() != 0) begin
            fail("done_timeout", done_q.size(), 0);
            done_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rel(input int a, input int r);
        for (int i = 0; i < 1000 && cyc < a + r; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_env"}, int'(ir_env), 1);
        chk({n, "_mod"}, int'(ir_mod), 0);
        chk({n, "_busy"}, int'(busy), 0);
        chk({n, "_ready"}, int'(tx_ready), 1);
        chk({n, "_done"}, int'(done), 0);
    endtask

    int a0, a1, a2;
    int basic_msb[8] = '{1, 13, 19, 23, 29, 39, 43, 49};
    int basic_lsb[8] = '{1, 13, 19, 23, 29, 39, 45, 49};

    initial begin
        vecs[0] = '{3'b101, 2'b01, 1'b1, 2'd0, 50};
        vecs[1] = '{3'b101, 2'b01, 1'b0, 2'd0, 50};
        vecs[2] = '{3'b101, 2'b01, 1'b1, 2'd2, 160};
        vecs[3] = '{3'b000, 2'b00, 1'b1, 2'd0, 44};
        vecs[4] = '{3'b111, 2'b11, 1'b0, 2'd1, 113};
        vecs[5] = '{3'b100, 2'b10, 1'b0, 2'd3, 207};
        vecs[6] = '{3'b011, 2'b10, 1'b1, 2'd0, 50};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            set_cmd(vecs[i].s0, vecs[i].s1, vecs[i].msb, vecs[i].rpt, vecs[i].busy);
            rise_log.delete();
            send(a0);
            wait_done();
            chk($sformatf("v%0d_marks", i), rise_log.size(), 8 * (int'(vecs[i].rpt) + 1));
            if (i == 0 || i == 1)
                for (int k = 0; k < 8 && k < rise_log.size(); k++)
                    chk($sformatf("v%0d_win%0d", i, k), rise_log[k],
                        (i == 0) ? basic_msb[k] : basic_lsb[k]);
            if (i == 2 && rise_log.size() > 8)
                chk("rpt_hdr2", rise_log[8], 56);
            @(posedge clk); #1;
        end

        // Back-to-back: valid held through the whole frame.
        set_cmd(3'b101, 2'b01, 1'b1, 2'd0, 50);
        tx_valid = 1'b1;
        wait_accept(a1);
        @(posedge clk); #1;
        chk("b2b_busy_ignore", int'(busy), 1);
        wait_accept(a2);
        chk("b2b_accept", a2 - a1, 51);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_done();

        // Abort in cycle 20, new command accepted in cycle 21.
        set_cmd(3'b101, 2'b01, 1'b1, 2'd0, 50);
        send(a0);
        wait_rel(a0, 20);
        abort = 1'b1;
        set_cmd(3'b000, 2'b00, 1'b1, 2'd0, 44);
        tx_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("abort_reaccept", acc_cyc - a0, 21);
        wait_done();

        // Reset in cycle 30 with valid held; accepted once reset releases.
        set_cmd(3'b101, 2'b01, 1'b1, 2'd0, 50);
        send(a0);
        wait_rel(a0, 30);
        rst = 1'b0;
        set_cmd(3'b011, 2'b10, 1'b1, 2'd0, 50);
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst = 1'b1;
            @(negedge clk);
            if (k < 2) chk_idle($sformatf("rst%0d", k));
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("rst_reaccept", acc_cyc - a0, 33);
        wait_done();

        repeat (3) @(posedge clk);
        chk("sb_empty", mark_q.size() + done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
